instr_encoder: RTL and testbench

Sequential MIPS instruction encoder. It accepts field-level instruction requests over a valid/ready handshake and packs them into 32-bit MIPS words. Words are emitted with their target instruction-memory address over a second valid/ready handshake. It sits between the test/program-generation front end and instruction memory, producing the words the pipeline decoder consumes. Optional pseudo-instruction expansion turns `LI` into a `LUI`/`ORI` pair.

---
 rtl/instr_encoder_if.sv | 40 ++++
 rtl/instr_encoder.sv | 146 ++++++++++++++
 tb/tb_instr_encoder.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_if
// Description : Request, output-word and address-control bundle of the MIPS
//               instruction encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_if;
   logic        w_req_valid;
   logic        w_req_ready;
   logic [1:0]  w_req_kind_2;
   logic [5:0]  w_req_op_6;
   logic [4:0]  w_req_rs_5;
   logic [4:0]  w_req_rt_5;
   logic [4:0]  w_req_rd_5;
   logic [4:0]  w_req_sh_5;
   logic [31:0] w_req_imm_32;
   logic        w_out_valid;
   logic        w_out_ready;
   logic [31:0] w_out_instr_32;
   logic [31:0] w_out_addr_32;
   logic        w_addr_load;
   logic [31:0] w_addr_val_32;
   logic [15:0] w_count_16;

   modport master (
      output w_req_valid, w_req_kind_2, w_req_op_6, w_req_rs_5, w_req_rt_5,
             w_req_rd_5, w_req_sh_5, w_req_imm_32, w_out_ready, w_addr_load,
             w_addr_val_32,
      input  w_req_ready, w_out_valid, w_out_instr_32, w_out_addr_32, w_count_16
   );

   modport slave (
      input  w_req_valid, w_req_kind_2, w_req_op_6, w_req_rs_5, w_req_rt_5,
             w_req_rd_5, w_req_sh_5, w_req_imm_32, w_out_ready, w_addr_load,
             w_addr_val_32,
      output w_req_ready, w_out_valid, w_out_instr_32, w_out_addr_32, w_count_16
   );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Packs field-level requests into 32-bit MIPS words with their
//               instruction-memory address. ENC_PSEUDO_EN enables LI -> LUI/ORI.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
   parameter logic [31:0] ADDR_STEP = 32'd4
) (
   input  logic            clock,
   input  logic            reset,
   instr_encoder_if.slave  bus
);

   localparam logic [5:0] c_OP_ORI = 6'h0D;
   localparam logic [5:0] c_OP_LUI = 6'h0F;

`ifdef ENC_PSEUDO_EN
   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_LI2  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pend_q, pend_d;
`endif

   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] count_q, count_d;

   logic        w_idle;
   logic        w_accept;
   logic        w_out_hs;
   logic        w_load_eff;
   logic        w_two_word;
   logic [31:0] w_word1;
   logic [31:0] w_word2;

`ifdef ENC_PSEUDO_EN
   assign w_idle = (state_q == S_IDLE);
`else
   assign w_idle = 1'b1;
`endif

   assign bus.w_req_ready = w_idle & ~bus.w_addr_load & (~valid_q | bus.w_out_ready);
   assign w_accept        = bus.w_req_valid & bus.w_req_ready;
   assign w_out_hs        = valid_q & bus.w_out_ready;
   assign w_load_eff      = bus.w_addr_load & w_idle & ~valid_q;

   always_comb begin
      w_word1    = 32'h0000_0000;
      w_word2    = 32'h0000_0000;
      w_two_word = 1'b0;
      case (bus.w_req_kind_2)
         2'd0: w_word1 = {6'h00, bus.w_req_rs_5, bus.w_req_rt_5, bus.w_req_rd_5,
                          bus.w_req_sh_5, bus.w_req_op_6};
         2'd1: w_word1 = {bus.w_req_op_6, bus.w_req_rs_5, bus.w_req_rt_5,
                          bus.w_req_imm_32[15:0]};
         2'd2: w_word1 = {bus.w_req_op_6, bus.w_req_imm_32[25:0]};
         default: begin
`ifdef ENC_PSEUDO_EN
            // LI collapses to one word when either half of the constant is zero.
            if (bus.w_req_op_6 == 6'd1) begin
               if (bus.w_req_imm_32[31:16] == 16'h0000) begin
                  w_word1 = {c_OP_ORI, 5'd0, bus.w_req_rt_5, bus.w_req_imm_32[15:0]};
               end else begin
                  w_word1 = {c_OP_LUI, 5'd0, bus.w_req_rt_5, bus.w_req_imm_32[31:16]};
                  if (bus.w_req_imm_32[15:0] != 16'h0000) begin
                     w_two_word = 1'b1;
                     w_word2    = {c_OP_ORI, bus.w_req_rt_5, bus.w_req_rt_5,
                                   bus.w_req_imm_32[15:0]};
                  end
               end
            end
`endif
         end
      endcase
   end

   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      addr_d  = addr_q;
      count_d = count_q;
`ifdef ENC_PSEUDO_EN
      state_d = state_q;
      pend_d  = pend_q;
`endif
      if (w_out_hs) begin
         valid_d = 1'b0;
         addr_d  = addr_q + ADDR_STEP;
         count_d = count_q + 16'd1;
      end else if (w_load_eff) begin
         addr_d  = bus.w_addr_val_32;
         count_d = 16'd0;
      end

      if (w_accept) begin
         valid_d = 1'b1;
         instr_d = w_word1;
`ifdef ENC_PSEUDO_EN
         if (w_two_word) begin
            pend_d  = w_word2;
            state_d = S_LI2;
         end
      end else if ((state_q == S_LI2) && w_out_hs) begin
         valid_d = 1'b1;
         instr_d = pend_q;
         state_d = S_IDLE;
`endif
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         instr_q <= 32'h0000_0000;
         addr_q  <= BASE_ADDR;
         count_q <= 16'd0;
`ifdef ENC_PSEUDO_EN
         state_q <= S_IDLE;
         pend_q  <= 32'h0000_0000;
`endif
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         addr_q  <= addr_d;
         count_q <= count_d;
`ifdef ENC_PSEUDO_EN
         state_q <= state_d;
         pend_q  <= pend_d;
`endif
      end
   end

   assign bus.w_out_valid    = valid_q;
   assign bus.w_out_instr_32 = instr_q;
   assign bus.w_out_addr_32  = addr_q;
   assign bus.w_count_16     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed self-checking bench for instr_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

   localparam logic [31:0] c_BASE = 32'h0100_0000;

`ifdef ENC_PSEUDO_EN
   localparam logic [31:0] c_LI_LUI   = 32'h3C09_1234;
   localparam logic [31:0] c_LI_ORI   = 32'h3529_5678;
   localparam logic [31:0] c_LI_SMALL = 32'h3404_0042;
   localparam logic [31:0] c_LI_HIGH  = 32'h3C04_ABCD;
   localparam logic        c_LI_READY = 1'b0;
   localparam logic        c_LI_V2    = 1'b1;
   localparam logic [15:0] c_LI_CNT   = 16'd2;
`else
   localparam logic [31:0] c_LI_LUI   = 32'h0000_0000;
   localparam logic [31:0] c_LI_SMALL = 32'h0000_0000;
   localparam logic [31:0] c_LI_HIGH  = 32'h0000_0000;
   localparam logic        c_LI_READY = 1'b1;
   localparam logic        c_LI_V2    = 1'b0;
   localparam logic [15:0] c_LI_CNT   = 16'd1;
`endif

   logic clock;
   logic reset;
   int   tests_run;
   int   tests_failed;

   instr_encoder_if bus();

   instr_encoder #(.BASE_ADDR(c_BASE), .ADDR_STEP(32'd4)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic do_reset();
      reset = 1'b1;
      bus.w_req_valid = 1'b0;
      bus.w_addr_load = 1'b0;
      bus.w_out_ready = 1'b1;
      #12;
      @(negedge clock);
      reset = 1'b0;
   endtask

   // Returns at the falling edge right after the request was accepted.
   task automatic send(input logic [1:0] kind, input logic [5:0] op,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh,
                       input logic [31:0] imm);
      int n;
      n = 0;
      @(negedge clock);
      bus.w_req_kind_2 = kind;
      bus.w_req_op_6   = op;
      bus.w_req_rs_5   = rs;
      bus.w_req_rt_5   = rt;
      bus.w_req_rd_5   = rd;
      bus.w_req_sh_5   = sh;
      bus.w_req_imm_32 = imm;
      bus.w_req_valid  = 1'b1;
      #1;
      while (!bus.w_req_ready && n < 20) begin
         @(negedge clock);
         #1;
         n++;
      end
      tests_run++;
      if (bus.w_req_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL send_timeout: req_ready=%b required 1", bus.w_req_ready);
      end
      @(negedge clock);
      bus.w_req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.w_req_valid = 1'b0;
      bus.w_addr_load = 1'b0;
      bus.w_out_ready = 1'b0;
      #12;
      tests_run++;
      if (bus.w_out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b required 0", bus.w_out_valid); end
      tests_run++;
      if (bus.w_out_instr_32 !== 32'h0) begin tests_failed++; $display("FAIL rst_instr: got %h required 0", bus.w_out_instr_32); end
      tests_run++;
      if (bus.w_out_addr_32 !== c_BASE) begin tests_failed++; $display("FAIL rst_addr: got %h required %h", bus.w_out_addr_32, c_BASE); end
      tests_run++;
      if (bus.w_count_16 !== 16'd0) begin tests_failed++; $display("FAIL rst_count: got %0d required 0", bus.w_count_16); end
      @(negedge clock);
      reset = 1'b0;
      #1;
      tests_run++;
      if (bus.w_req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ready: got %b required 1", bus.w_req_ready); end
   endtask

   task automatic test_rtype();
      do_reset();
      send(2'd0, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
      tests_run++;
      if (bus.w_out_valid !== 1'b1 || bus.w_out_instr_32 !== 32'h0022_1820) begin
         tests_failed++; $display("FAIL add_word: got v=%b %h required v=1 00221820", bus.w_out_valid, bus.w_out_instr_32);
      end
      tests_run++;
      if (bus.w_out_addr_32 !== c_BASE) begin tests_failed++; $display("FAIL add_addr: got %h required %h", bus.w_out_addr_32, c_BASE); end
      @(negedge clock);
      tests_run++;
      if (bus.w_out_valid !== 1'b0 || bus.w_count_16 !== 16'd1) begin
         tests_failed++; $display("FAIL add_count: got v=%b cnt=%0d required v=0 cnt=1", bus.w_out_valid, bus.w_count_16);
      end
   endtask

   task automatic test_ij();
      do_reset();
      send(2'd1, 6'h09, 5'd0, 5'd8, 5'd0, 5'd0, 32'h0000_FFFF);
      tests_run++;
      if (bus.w_out_instr_32 !== 32'h2408_FFFF || bus.w_out_addr_32 !== c_BASE) begin
         tests_failed++; $display("FAIL addiu: got %h @%h required 2408ffff @%h", bus.w_out_instr_32, bus.w_out_addr_32, c_BASE);
      end
      send(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0004_0000);
      tests_run++;
      if (bus.w_out_instr_32 !== 32'h0804_0000 || bus.w_out_addr_32 !== c_BASE + 32'd4) begin
         tests_failed++; $display("FAIL jump: got %h @%h required 08040000 @%h", bus.w_out_instr_32, bus.w_out_addr_32, c_BASE + 32'd4);
      end
   endtask

   task automatic test_li();
      do_reset();
      send(2'd3, 6'd1, 5'd0, 5'd9, 5'd0, 5'd0, 32'h1234_5678);
      tests_run++;
      if (bus.w_out_valid !== 1'b1 || bus.w_out_instr_32 !== c_LI_LUI) begin
         tests_failed++; $display("FAIL li_first: got v=%b %h required v=1 %h", bus.w_out_valid, bus.w_out_instr_32, c_LI_LUI);
      end
      tests_run++;
      if (bus.w_req_ready !== c_LI_READY) begin tests_failed++; $display("FAIL li_ready: got %b required %b", bus.w_req_ready, c_LI_READY); end
      @(negedge clock);
      tests_run++;
      if (bus.w_out_valid !== c_LI_V2) begin tests_failed++; $display("FAIL li_second_valid: got %b required %b", bus.w_out_valid, c_LI_V2); end
`ifdef ENC_PSEUDO_EN
      tests_run++;
      if (bus.w_out_instr_32 !== c_LI_ORI || bus.w_out_addr_32 !== c_BASE + 32'd4) begin
         tests_failed++; $display("FAIL li_ori: got %h @%h required %h @%h", bus.w_out_instr_32, bus.w_out_addr_32, c_LI_ORI, c_BASE + 32'd4);
      end
`endif
      @(negedge clock);
      tests_run++;
      if (bus.w_out_valid !== 1'b0 || bus.w_count_16 !== c_LI_CNT) begin
         tests_failed++; $display("FAIL li_count: got v=%b cnt=%0d required v=0 cnt=%0d", bus.w_out_valid, bus.w_count_16, c_LI_CNT);
      end
      send(2'd3, 6'd1, 5'd0, 5'd4, 5'd0, 5'd0, 32'h0000_0042);
      tests_run++;
      if (bus.w_out_instr_32 !== c_LI_SMALL) begin tests_failed++; $display("FAIL li_small: got %h required %h", bus.w_out_instr_32, c_LI_SMALL); end
      @(negedge clock);
      tests_run++;
      if (bus.w_out_valid !== 1'b0) begin tests_failed++; $display("FAIL li_small_single: got v=%b required 0", bus.w_out_valid); end
      send(2'd3, 6'd1, 5'd0, 5'd4, 5'd0, 5'd0, 32'hABCD_0000);
      tests_run++;
      if (bus.w_out_instr_32 !== c_LI_HIGH) begin tests_failed++; $display("FAIL li_high: got %h required %h", bus.w_out_instr_32, c_LI_HIGH); end
      @(negedge clock);
      tests_run++;
      if (bus.w_out_valid !== 1'b0) begin tests_failed++; $display("FAIL li_high_single: got v=%b required 0", bus.w_out_valid); end
      send(2'd3, 6'd5, 5'd1, 5'd2, 5'd3, 5'd4, 32'hFFFF_FFFF);
      tests_run++;
      if (bus.w_out_instr_32 !== 32'h0) begin tests_failed++; $display("FAIL pseudo_reserved: got %h required 0", bus.w_out_instr_32); end
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.w_out_ready = 1'b0;
      send(2'd0, 6'h22, 5'd4, 5'd5, 5'd6, 5'd0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (bus.w_out_valid !== 1'b1 || bus.w_out_instr_32 !== 32'h0085_3022 ||
             bus.w_out_addr_32 !== c_BASE || bus.w_req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_%0d: got v=%b %h @%h rdy=%b required v=1 00853022 @%h rdy=0",
                     i, bus.w_out_valid, bus.w_out_instr_32, bus.w_out_addr_32, bus.w_req_ready, c_BASE);
         end
         @(negedge clock);
      end
      bus.w_out_ready = 1'b1;
      @(negedge clock);
      tests_run++;
      if (bus.w_out_valid !== 1'b0 || bus.w_count_16 !== 16'd1) begin
         tests_failed++; $display("FAIL hold_drain: got v=%b cnt=%0d required v=0 cnt=1", bus.w_out_valid, bus.w_count_16);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_w [4];
      exp_w[0] = 32'h0022_0820;
      exp_w[1] = 32'h0022_1020;
      exp_w[2] = 32'h0022_1820;
      exp_w[3] = 32'h0022_2020;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (i > 0) begin
            tests_run++;
            if (bus.w_out_valid !== 1'b1 || bus.w_out_instr_32 !== exp_w[i-1] ||
                bus.w_out_addr_32 !== c_BASE + 32'(4 * (i - 1))) begin
               tests_failed++;
               $display("FAIL stream_%0d: got v=%b %h @%h required v=1 %h @%h", i - 1,
                        bus.w_out_valid, bus.w_out_instr_32, bus.w_out_addr_32, exp_w[i-1], c_BASE + 32'(4 * (i - 1)));
            end
         end
         if (i < 4) begin
            bus.w_req_kind_2 = 2'd0; bus.w_req_op_6 = 6'h20;
            bus.w_req_rs_5 = 5'd1; bus.w_req_rt_5 = 5'd2;
            bus.w_req_rd_5 = 5'(i + 1); bus.w_req_sh_5 = 5'd0;
            bus.w_req_imm_32 = 32'h0;
            bus.w_req_valid = 1'b1;
         end else begin
            bus.w_req_valid = 1'b0;
         end
      end
      @(negedge clock);
      tests_run++;
      if (bus.w_out_valid !== 1'b0 || bus.w_count_16 !== 16'd4 || bus.w_out_addr_32 !== c_BASE + 32'd16) begin
         tests_failed++; $display("FAIL stream_end: got v=%b cnt=%0d @%h required v=0 cnt=4 @%h",
                                  bus.w_out_valid, bus.w_count_16, bus.w_out_addr_32, c_BASE + 32'd16);
      end
   endtask

   task automatic test_addr_reload();
      do_reset();
      @(negedge clock);
      bus.w_addr_load = 1'b1;
      bus.w_addr_val_32 = 32'h0040_0000;
      #1;
      tests_run++;
      if (bus.w_req_ready !== 1'b0) begin tests_failed++; $display("FAIL load_blocks: got rdy=%b required 0", bus.w_req_ready); end
      @(negedge clock);
      bus.w_addr_load = 1'b0;
      send(2'd0, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
      tests_run++;
      if (bus.w_out_addr_32 !== 32'h0040_0000) begin tests_failed++; $display("FAIL load_addr: got %h required 00400000", bus.w_out_addr_32); end
      @(negedge clock);
      tests_run++;
      if (bus.w_count_16 !== 16'd1 || bus.w_out_addr_32 !== 32'h0040_0004) begin
         tests_failed++; $display("FAIL load_count: got cnt=%0d @%h required cnt=1 @00400004", bus.w_count_16, bus.w_out_addr_32);
      end
      bus.w_out_ready = 1'b0;
      send(2'd0, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
      bus.w_addr_load = 1'b1;
      bus.w_addr_val_32 = 32'h0080_0000;
      @(negedge clock);
      bus.w_addr_load = 1'b0;
      tests_run++;
      if (bus.w_out_addr_32 !== 32'h0040_0004 || bus.w_count_16 !== 16'd1) begin
         tests_failed++; $display("FAIL load_ignored: got @%h cnt=%0d required @00400004 cnt=1", bus.w_out_addr_32, bus.w_count_16);
      end
      bus.w_out_ready = 1'b1;
      @(negedge clock);
      tests_run++;
      if (bus.w_count_16 !== 16'd2 || bus.w_out_addr_32 !== 32'h0040_0008) begin
         tests_failed++; $display("FAIL load_after: got cnt=%0d @%h required cnt=2 @00400008", bus.w_count_16, bus.w_out_addr_32);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.w_out_ready = 1'b0;
      send(2'd3, 6'd1, 5'd0, 5'd9, 5'd0, 5'd0, 32'h1234_5678);
      #2;
      reset = 1'b1;
      #1;
      tests_run++;
      if (bus.w_out_valid !== 1'b0 || bus.w_out_instr_32 !== 32'h0 ||
          bus.w_out_addr_32 !== c_BASE || bus.w_count_16 !== 16'd0) begin
         tests_failed++; $display("FAIL mid_reset: got v=%b %h @%h cnt=%0d required v=0 0 @%h cnt=0",
                                  bus.w_out_valid, bus.w_out_instr_32, bus.w_out_addr_32, bus.w_count_16, c_BASE);
      end
      @(negedge clock);
      reset = 1'b0;
      bus.w_out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         tests_run++;
         if (bus.w_out_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_no_ori_%0d: got v=%b %h required v=0", i, bus.w_out_valid, bus.w_out_instr_32); end
      end
      send(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0004_0000);
      tests_run++;
      if (bus.w_out_instr_32 !== 32'h0804_0000 || bus.w_out_addr_32 !== c_BASE) begin
         tests_failed++; $display("FAIL mid_after: got %h @%h required 08040000 @%h", bus.w_out_instr_32, bus.w_out_addr_32, c_BASE);
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      reset = 1'b1;
      bus.w_req_valid = 1'b0;
      bus.w_req_kind_2 = 2'd0;
      bus.w_req_op_6 = 6'd0;
      bus.w_req_rs_5 = 5'd0;
      bus.w_req_rt_5 = 5'd0;
      bus.w_req_rd_5 = 5'd0;
      bus.w_req_sh_5 = 5'd0;
      bus.w_req_imm_32 = 32'h0;
      bus.w_out_ready = 1'b0;
      bus.w_addr_load = 1'b0;
      bus.w_addr_val_32 = 32'h0;
      test_reset();
      test_rtype();
      test_ij();
      test_li();
      test_backpressure();
      test_back_to_back();
      test_addr_reload();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
